uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver. It drains bytes from the receiver's `data_ready`/`data_out`/`read_en` handshake into a DEPTH-entry circular FIFO and presents a first-word-fall-through read port to the processor's device bus. While the FIFO is full it applies back-pressure: the pending byte stays held in the receiver and a sticky stall flag is raised.

---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between the UART receiver handshake and the device bus.
// Captures receiver bytes into a circular buffer and back-pressures (sticky stall) when full.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     rx_ready,
    input  logic [WIDTH-1:0]         rx_data,
    output logic                     rx_read_en,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     stalled,
    input  logic                     clear_stalled
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

    state_t             state_q;
    logic               read_en_q;
    logic               stalled_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               full_w, wr_w, pop_w, stall_w;

    // Capture decisions use the pre-edge full flag, so a same-cycle pop never frees a slot early.
    assign full_w  = (count_q == FULL_CNT);
    assign wr_w    = (state_q == IDLE) && rx_ready && !full_w;
    assign stall_w = (state_q == IDLE) && rx_ready && full_w;
    assign pop_w   = rd_en && (count_q != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            read_en_q <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_w) begin
                        state_q   <= ACK;
                        read_en_q <= 1'b1;
                    end
                end
                ACK: begin
                    state_q   <= WAIT;
                    read_en_q <= 1'b0;
                end
                WAIT: begin
                    // Hold off until the receiver drops data_ready so one byte is never taken twice.
                    if (!rx_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    read_en_q <= 1'b0;
                end
            endcase

            if (stall_w) begin
                stalled_q <= 1'b1;
            end else if (clear_stalled) begin
                stalled_q <= 1'b0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_w) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_w, pop_w})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_w) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rx_read_en = read_en_q;
    assign stalled    = stalled_q;
    assign rd_data    = mem_q[rd_ptr_q];
    assign rd_valid   = (count_q != '0);
    assign count      = count_q;
    assign full       = full_w;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus directed scenarios.
module tb_uart_rx_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             rx_ready = 1'b0;
    logic [WIDTH-1:0] rx_data = '0;
    logic             rx_read_en;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [4:0]       count;
    logic             full;
    logic             stalled;
    logic             clear_stalled = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_read_en(rx_read_en), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .full(full), .stalled(stalled), .clear_stalled(clear_stalled)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: stored bytes as a queue, capture gating as "busy until receiver lets go".
    logic [WIDTH-1:0] mq[$];
    bit m_ack = 1'b0;
    bit m_stl = 1'b0;
    bit m_busy = 1'b0;
    bit m_ackdue = 1'b0;
    bit m_full, m_cap, m_pop;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ack = 1'b0; m_stl = 1'b0; m_busy = 1'b0; m_ackdue = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_cap  = !m_busy && rx_ready && !m_full;
            m_pop  = rd_en && (mq.size() != 0);
            if (!m_busy && rx_ready && m_full) m_stl = 1'b1;
            else if (clear_stalled) m_stl = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if (m_cap) mq.push_back(rx_data);
            // Busy covers the ack cycle and every cycle until rx_ready is seen low afterwards.
            if (m_cap) begin
                m_busy = 1'b1; m_ackdue = 1'b1;
            end else if (m_ackdue) begin
                m_ackdue = 1'b0;
            end else if (m_busy && !rx_ready) begin
                m_busy = 1'b0;
            end
            m_ack = m_cap;
        end
    end

    always @(negedge clock) begin
        check("cmp_rx_read_en", 32'(rx_read_en), 32'(m_ack));
        check("cmp_count", 32'(count), 32'(mq.size()));
        check("cmp_full", 32'(full), 32'(mq.size() == DEPTH));
        check("cmp_rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
        check("cmp_stalled", 32'(stalled), 32'(m_stl));
        check("cmp_count_bound", 32'(count <= 5'(DEPTH)), 32'(1));
        if (mq.size() != 0) check("cmp_rd_data", 32'(rd_data), 32'(mq[0]));
    end

    task automatic present(input logic [7:0] b);
        @(negedge clock);
        rx_ready = 1'b1;
        rx_data  = b;
    endtask

    task automatic wait_ack(input int budget, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (rx_read_en) seen = 1'b1;
        end
        check({nm, "_ack"}, 32'(seen), 32'(1));
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        present(b);
        wait_ack(6, "send");
    endtask

    task automatic pop(input logic [7:0] exp, input string nm);
        @(negedge clock);
        check({nm, "_valid"}, 32'(rd_valid), 32'(1));
        check({nm, "_data"}, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset with a byte already waiting in the receiver
        rx_ready = 1'b1;
        rx_data  = 8'hA5;
        #1 reset_n = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("rst_read_en", 32'(rx_read_en), 32'(0));
            check("rst_count", 32'(count), 32'(0));
        end
        reset_n = 1'b1;
        @(negedge clock);
        check("rel_ack", 32'(rx_read_en), 32'(1));
        check("rel_count", 32'(count), 32'(1));
        check("rel_data", 32'(rd_data), 32'hA5);
        check("rel_valid", 32'(rd_valid), 32'(1));
        @(negedge clock);
        check("rel_ack_one_cycle", 32'(rx_read_en), 32'(0));
        rx_ready = 1'b0;
        pop(8'hA5, "rel_pop");

        // Three bytes in order, then an underflow attempt
        send(8'h01); send(8'h02); send(8'h03);
        @(negedge clock);
        check("three_count", 32'(count), 32'(3));
        pop(8'h01, "p1"); pop(8'h02, "p2"); pop(8'h03, "p3");
        check("empty_valid", 32'(rd_valid), 32'(0));
        @(negedge clock); rd_en = 1'b1;
        @(negedge clock); rd_en = 1'b0;
        check("underflow_count", 32'(count), 32'(0));

        // Fill, stall, pop to free a slot
        for (int i = 0; i < DEPTH; i++) send(8'(i));
        @(negedge clock);
        check("fill_full", 32'(full), 32'(1));
        check("fill_count", 32'(count), 32'(16));
        present(8'h7E);
        clear_stalled = 1'b1;
        @(negedge clock);
        clear_stalled = 1'b0;
        check("stall_over_clear", 32'(stalled), 32'(1));
        repeat (3) begin
            @(negedge clock);
            check("stall_no_ack", 32'(rx_read_en), 32'(0));
        end
        pop(8'h00, "stall_pop");
        wait_ack(3, "stall_release");
        check("stall_refill_count", 32'(count), 32'(16));
        @(negedge clock); clear_stalled = 1'b1;
        @(negedge clock); clear_stalled = 1'b0;
        check("stall_cleared", 32'(stalled), 32'(0));
        for (int i = 1; i < DEPTH; i++) pop(8'(i), "drain");
        pop(8'h7E, "drain_7e");
        check("drain_empty", 32'(rd_valid), 32'(0));

        // Wrap-around: 40 bytes through the ring
        for (int i = 0; i < 40; i++) begin
            send(8'(i));
            if (i >= 3) pop(8'(i - 3), "wrap");
        end
        pop(8'd37, "wrap_tail"); pop(8'd38, "wrap_tail"); pop(8'd39, "wrap_tail");
        check("wrap_empty", 32'(count), 32'(0));

        // Simultaneous capture and pop at count 5
        for (int i = 0; i < 5; i++) send(8'(8'h50 + i));
        @(negedge clock);
        rx_ready = 1'b1; rx_data = 8'h55; rd_en = 1'b1;
        check("simul_head_before", 32'(rd_data), 32'h50);
        @(negedge clock);
        rd_en = 1'b0;
        check("simul_count", 32'(count), 32'(5));
        check("simul_head_after", 32'(rd_data), 32'h51);
        check("simul_ack", 32'(rx_read_en), 32'(1));
        @(negedge clock);
        rx_ready = 1'b0;
        pop(8'h51, "simul_pop"); pop(8'h52, "simul_pop");

        // Asynchronous reset in the middle of the ack pulse with count 4
        present(8'h66);
        @(negedge clock);
        check("pre_rst_ack", 32'(rx_read_en), 32'(1));
        check("pre_rst_count", 32'(count), 32'(4));
        #2 reset_n = 1'b0;
        #1;
        check("async_read_en", 32'(rx_read_en), 32'(0));
        check("async_count", 32'(count), 32'(0));
        check("async_valid", 32'(rd_valid), 32'(0));
        check("async_full", 32'(full), 32'(0));
        check("async_stalled", 32'(stalled), 32'(0));
        @(negedge clock);
        reset_n = 1'b1;
        wait_ack(3, "post_rst");
        pop(8'h66, "post_rst_pop");
        check("post_rst_empty", 32'(rd_valid), 32'(0));

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
